// File: rtl/uart_cfg_regs.sv
// UART configuration registers with idle-gated shadow commit and an
// oversample/baud tick generator driven by the active divisor and prescale.
module uart_cfg_regs #(
  parameter int DIV_WIDTH       = 16,
  parameter int DEF_PRESCALE    = 32,
  parameter int DEF_DIVISOR     = 14,
  parameter int DEF_PARITY_EN   = 1,
  parameter int DEF_PARITY_TYPE = 0,
  parameter int DEF_ENABLE      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_wr_en,
  input  logic                 cfg_rd_en,
  input  logic [1:0]           cfg_addr,
  input  logic [31:0]          cfg_wdata,
  output logic [31:0]          cfg_rdata,
  output logic                 cfg_rd_valid,
  input  logic                 uart_busy,
  output logic                 uart_enable,
  output logic                 uart_parity_enable,
  output logic                 uart_parity_type,
  output logic [5:0]           uart_prescale,
  output logic [DIV_WIDTH-1:0] uart_divisor,
  output logic                 uart_os_tick,
  output logic                 uart_baud_tick,
  output logic                 cfg_update_pending,
  output logic                 cfg_error
);

  localparam logic [5:0]           DEF_PRESC_L = 6'(DEF_PRESCALE);
  localparam logic [DIV_WIDTH-1:0] DEF_DIV_L   = DIV_WIDTH'(DEF_DIVISOR);
  localparam logic                 DEF_PEN_L   = 1'(DEF_PARITY_EN);
  localparam logic                 DEF_PTYP_L  = 1'(DEF_PARITY_TYPE);
  localparam logic                 DEF_EN_L    = 1'(DEF_ENABLE);

  function automatic logic prescale_legal(input logic [5:0] p);
    return (p == 6'd8) || (p == 6'd16) || (p == 6'd32);
  endfunction

  logic                 sh_par_en, sh_par_type, sh_enable;
  logic [5:0]           sh_prescale;
  logic [DIV_WIDTH-1:0] sh_divisor;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [5:0]           os_cnt;
  logic [31:0]          rd_mux;

  logic wr_ctrl, wr_div, wr_status, ctrl_ok, div_ok;
  logic wr_legal, wr_illegal, commit, clear_cnt, div_wrap, os_wrap;

  assign wr_ctrl    = cfg_wr_en && (cfg_addr == 2'd0);
  assign wr_div     = cfg_wr_en && (cfg_addr == 2'd1);
  assign wr_status  = cfg_wr_en && (cfg_addr == 2'd2);
  assign ctrl_ok    = prescale_legal(cfg_wdata[7:2]);
  assign div_ok     = (cfg_wdata[DIV_WIDTH-1:0] != '0);
  assign wr_legal   = (wr_ctrl && ctrl_ok) || (wr_div && div_ok);
  assign wr_illegal = (wr_ctrl && !ctrl_ok) || (wr_div && !div_ok);
  // Commit samples the shadow as it stood before any same-cycle write.
  assign commit     = cfg_update_pending && !uart_busy;
  assign clear_cnt  = commit || !uart_enable;
  assign div_wrap   = (div_cnt == uart_divisor - 1'b1);
  assign os_wrap    = (os_cnt == uart_prescale - 6'd1);

  always_comb begin
    rd_mux = '0;
    case (cfg_addr)
      2'd0: rd_mux = {23'd0, sh_enable, sh_prescale, sh_par_type, sh_par_en};
      2'd1: rd_mux[DIV_WIDTH-1:0] = sh_divisor;
      2'd2: rd_mux = {29'd0, cfg_error, uart_enable, cfg_update_pending};
      default: rd_mux = '0;
    endcase
  end

  // Shadow, active, pending and error state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_par_en          <= DEF_PEN_L;
      sh_par_type        <= DEF_PTYP_L;
      sh_prescale        <= DEF_PRESC_L;
      sh_enable          <= DEF_EN_L;
      sh_divisor         <= DEF_DIV_L;
      uart_parity_enable <= DEF_PEN_L;
      uart_parity_type   <= DEF_PTYP_L;
      uart_prescale      <= DEF_PRESC_L;
      uart_enable        <= DEF_EN_L;
      uart_divisor       <= DEF_DIV_L;
      cfg_update_pending <= 1'b0;
      cfg_error          <= 1'b0;
    end else begin
      if (commit) begin
        uart_parity_enable <= sh_par_en;
        uart_parity_type   <= sh_par_type;
        uart_prescale      <= sh_prescale;
        uart_enable        <= sh_enable;
        uart_divisor       <= sh_divisor;
      end
      if (wr_ctrl && ctrl_ok) begin
        sh_par_en   <= cfg_wdata[0];
        sh_par_type <= cfg_wdata[1];
        sh_prescale <= cfg_wdata[7:2];
        sh_enable   <= cfg_wdata[8];
      end
      if (wr_div && div_ok) sh_divisor <= cfg_wdata[DIV_WIDTH-1:0];
      if (wr_legal)    cfg_update_pending <= 1'b1;
      else if (commit) cfg_update_pending <= 1'b0;
      if (wr_illegal)                     cfg_error <= 1'b1;
      else if (wr_status && cfg_wdata[2]) cfg_error <= 1'b0;
    end
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_rdata    <= '0;
      cfg_rd_valid <= 1'b0;
    end else begin
      cfg_rd_valid <= cfg_rd_en;
      if (cfg_rd_en) cfg_rdata <= rd_mux;
    end
  end

  // Tick generator: divisor counter feeds the oversample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt        <= '0;
      os_cnt         <= '0;
      uart_os_tick   <= 1'b0;
      uart_baud_tick <= 1'b0;
    end else if (clear_cnt) begin
      div_cnt        <= '0;
      os_cnt         <= '0;
      uart_os_tick   <= 1'b0;
      uart_baud_tick <= 1'b0;
    end else if (div_wrap) begin
      div_cnt        <= '0;
      uart_os_tick   <= 1'b1;
      uart_baud_tick <= os_wrap;
      os_cnt         <= os_wrap ? 6'd0 : os_cnt + 6'd1;
    end else begin
      div_cnt        <= div_cnt + 1'b1;
      uart_os_tick   <= 1'b0;
      uart_baud_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cfg_regs.sv
// Directed bench for uart_cfg_regs: register access, commit gating,
// write legality, tick timing and asynchronous reset.
module tb_uart_cfg_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic        cfg_rd_en = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic        uart_busy = 1'b0;
  logic [31:0] cfg_rdata;
  logic        cfg_rd_valid;
  logic        uart_enable, uart_parity_enable, uart_parity_type;
  logic [5:0]  uart_prescale;
  logic [15:0] uart_divisor;
  logic        uart_os_tick, uart_baud_tick, cfg_update_pending, cfg_error;

  int total = 0;
  int bad   = 0;

  uart_cfg_regs dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rd_valid(cfg_rd_valid),
    .uart_busy(uart_busy), .uart_enable(uart_enable),
    .uart_parity_enable(uart_parity_enable), .uart_parity_type(uart_parity_type),
    .uart_prescale(uart_prescale), .uart_divisor(uart_divisor),
    .uart_os_tick(uart_os_tick), .uart_baud_tick(uart_baud_tick),
    .cfg_update_pending(cfg_update_pending), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    cfg_rd_en = 1'b1; cfg_addr = a;
    step();
    cfg_rd_en = 1'b0;
    chk({tag, "_vld"}, cfg_rd_valid, 1);
    chk(tag, cfg_rdata, exp);
  endtask

  task automatic chk_defaults(input string tag);
    chk({tag, "_en"}, uart_enable, 1);
    chk({tag, "_pen"}, uart_parity_enable, 1);
    chk({tag, "_ptyp"}, uart_parity_type, 0);
    chk({tag, "_presc"}, uart_prescale, 32);
    chk({tag, "_div"}, uart_divisor, 14);
    chk({tag, "_pend"}, cfg_update_pending, 0);
    chk({tag, "_err"}, cfg_error, 0);
    chk({tag, "_os"}, uart_os_tick, 0);
    chk({tag, "_baud"}, uart_baud_tick, 0);
  endtask

  initial begin
    int first_os;
    int nticks;

    step(); step();
    chk_defaults("rst");
    chk("rst_rdata", cfg_rdata, 0);
    chk("rst_rdvld", cfg_rd_valid, 0);

    rst_n = 1'b1;
    first_os = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (uart_os_tick && first_os == 0) first_os = k;
    end
    chk("first_os", first_os, 14);

    rd("rd_ctrl_def", 2'd0, 32'h181);
    rd("rd_div_def", 2'd1, 32'd14);
    rd("rd_stat_def", 2'd2, 32'h2);
    step();
    chk("rdvld_drop", cfg_rd_valid, 0);

    // DIV=4 then CTRL presc=8; CTRL lands in DIV's commit cycle, commits next
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h121);
    step();
    chk("div4", uart_divisor, 4);
    chk("presc8", uart_prescale, 8);
    chk("pend_clr", cfg_update_pending, 0);
    chk("os_commit", uart_os_tick, 0);
    for (int k = 1; k <= 64; k++) begin
      step();
      chk("os_pat", uart_os_tick, (k % 4 == 0) ? 1 : 0);
      chk("baud_pat", uart_baud_tick, (k % 32 == 0) ? 1 : 0);
    end

    // Busy holds the commit off
    uart_busy = 1'b1;
    wr(2'd0, 32'h141);
    chk("busy_pend", cfg_update_pending, 1);
    chk("busy_presc", uart_prescale, 8);
    rd("rd_ctrl_sh", 2'd0, 32'h141);
    rd("rd_stat_pend", 2'd2, 32'h3);

    // Read and write together: read returns pre-write value
    cfg_rd_en = 1'b1; cfg_wr_en = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h121;
    step();
    cfg_rd_en = 1'b0; cfg_wr_en = 1'b0;
    chk("rw_rdata", cfg_rdata, 32'h141);
    rd("rw_after", 2'd0, 32'h121);
    wr(2'd0, 32'h141);
    uart_busy = 1'b0;
    step();
    chk("idle_presc", uart_prescale, 16);
    chk("idle_pend", cfg_update_pending, 0);

    // Illegal writes
    wr(2'd0, 32'h131);
    chk("bad_ctrl_err", cfg_error, 1);
    chk("bad_ctrl_pend", cfg_update_pending, 0);
    wr(2'd1, 32'd0);
    chk("bad_div_err", cfg_error, 1);
    chk("bad_div_pend", cfg_update_pending, 0);
    rd("sh_ctrl_kept", 2'd0, 32'h141);
    rd("sh_div_kept", 2'd1, 32'd4);
    rd("stat_err", 2'd2, 32'h6);
    wr(2'd2, 32'h4);
    chk("w1c", cfg_error, 0);
    wr(2'd3, 32'hFFFF_FFFF);
    chk("addr3_pend", cfg_update_pending, 0);
    rd("stat_clean", 2'd2, 32'h2);

    // Write in the commit cycle of a previous write
    wr(2'd1, 32'd5);
    chk("d5_pend", cfg_update_pending, 1);
    chk("d5_div_old", uart_divisor, 4);
    wr(2'd1, 32'd7);
    chk("d7_div5", uart_divisor, 5);
    chk("d7_pend", cfg_update_pending, 1);
    step();
    chk("d7_div7", uart_divisor, 7);
    chk("d7_pend_clr", cfg_update_pending, 0);

    // Disable stops all ticks
    wr(2'd0, 32'h021);
    step();
    chk("dis_en", uart_enable, 0);
    nticks = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (uart_os_tick || uart_baud_tick) nticks++;
    end
    chk("dis_ticks", nticks, 0);
    rd("dis_stat", 2'd2, 32'h0);

    // Asynchronous reset with an update pending
    wr(2'd0, 32'h121);
    step();
    chk("reen", uart_enable, 1);
    uart_busy = 1'b1;
    wr(2'd1, 32'd9);
    repeat (5) step();
    chk("pre_rst_pend", cfg_update_pending, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_defaults("arst");
    chk("arst_rdvld", cfg_rd_valid, 0);
    step();
    chk("arst_os_hold", uart_os_tick, 0);
    rst_n = 1'b1;
    uart_busy = 1'b0;
    rd("arst_div", 2'd1, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
